// File: rtl/sipo_pkg.sv
// Shared types and defaults for the MSB-first serial-in/parallel-out receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } sipo_state_t;

  localparam int unsigned SIPO_DW_DEF = 4;

endpackage

// File: rtl/sipo_msb.sv
// MSB-first SIPO: frames on sof&enb, emits the word with a 1-cycle vld one clk after its last bit.
// Build with SIPO_PARITY_EN to add a trailing even-parity bit, a PAR state and the err port.
module sipo_msb
  import sipo_pkg::*;
#(
  parameter int unsigned DW = SIPO_DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic          sof,
  input  logic          inp,
  output logic [DW-1:0] out,
  output logic          vld,
  output logic          busy
`ifdef SIPO_PARITY_EN
  ,
  output logic          err
`endif
);

  localparam int unsigned CW = $clog2(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  sipo_state_t   state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] out_q, out_d;
  logic          vld_q, vld_d;
`ifdef SIPO_PARITY_EN
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    vld_d   = 1'b0;
`ifdef SIPO_PARITY_EN
    err_d   = err_q;
`endif
    if (enb) begin
      if (sof) begin
        // The first bit enters at the LSB and reaches the MSB after DW-1 shifts.
        state_d = SHIFT;
        shreg_d = {{(DW-1){1'b0}}, inp};
        cnt_d   = CW'(1);
      end else begin
        case (state_q)
          SHIFT: begin
            shreg_d = {shreg_q[DW-2:0], inp};
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
`ifdef SIPO_PARITY_EN
              state_d = PAR;
`else
              state_d = IDLE;
              out_d   = {shreg_q[DW-2:0], inp};
              vld_d   = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
`ifdef SIPO_PARITY_EN
          PAR: begin
            state_d = IDLE;
            out_d   = shreg_q;
            vld_d   = 1'b1;
            err_d   = (^shreg_q) ^ inp;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
`ifdef SIPO_PARITY_EN
      err_q   <= err_d;
`endif
    end
  end

  assign out  = out_q;
  assign vld  = vld_q;
  assign busy = (state_q != IDLE);
`ifdef SIPO_PARITY_EN
  assign err  = err_q;
`endif

endmodule

// File: tb/tb_sipo_msb.sv
// Directed bench for sipo_msb (DW=4); frames carry a trailing even-parity bit when SIPO_PARITY_EN is set.
module tb_sipo_msb;

  localparam int DW = 4;
`ifdef SIPO_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enb = 1'b0;
  logic          sof = 1'b0;
  logic          inp = 1'b0;
  logic [DW-1:0] out;
  logic          vld;
  logic          busy;
`ifdef SIPO_PARITY_EN
  logic          err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sipo_msb #(.DW(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .enb  (enb),
    .sof  (sof),
    .inp  (inp),
    .out  (out),
    .vld  (vld),
    .busy (busy)
`ifdef SIPO_PARITY_EN
    ,
    .err  (err)
`endif
  );

  // Drive one cycle of inputs, clock it, and settle 1 time unit past the edge.
  task automatic drive_bit(input logic e, input logic s, input logic d);
    enb = e;
    sof = s;
    inp = d;
    @(posedge clk);
    #1;
  endtask

  // Serial bit i of a frame: data MSB first, then (parity builds) the even-parity bit.
  function automatic logic frame_bit(input logic [DW-1:0] w, input int i);
    if (i < DW) return w[DW-1-i];
    return ^w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive_bit(1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, 1'b1, 1'b1);
    n_vec++;
    if (out !== 4'b0000) begin n_err++; $display("FAIL reset_out: got %b want 0000", out); end
    n_vec++;
    if (vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", vld); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_word();
    logic [DW-1:0] w;
    w = 4'b1011;
    for (int i = 0; i < NB; i++) begin
      drive_bit(1'b1, i == 0, frame_bit(w, i));
      n_vec++;
      if (i < NB - 1) begin
        if (vld !== 1'b0 || busy !== 1'b1) begin
          n_err++; $display("FAIL word_mid bit%0d: vld=%b busy=%b want vld=0 busy=1", i, vld, busy);
        end
      end else begin
        if (vld !== 1'b1 || out !== w || busy !== 1'b0) begin
          n_err++; $display("FAIL word_done: vld=%b out=%b busy=%b want 1 %b 0", vld, out, busy, w);
        end
      end
    end
    drive_bit(1'b0, 1'b0, 1'b0);
    n_vec++;
    if (vld !== 1'b0 || out !== w) begin
      n_err++; $display("FAIL word_hold: vld=%b out=%b want 0 %b", vld, out, w);
    end
  endtask

  task automatic test_gapped();
    logic [DW-1:0] w;
    w = 4'b0110;
    for (int i = 0; i < NB; i++) begin
      if (i == 2) begin
        for (int g = 0; g < 2; g++) begin
          drive_bit(1'b0, 1'b1, 1'b1);
          n_vec++;
          if (vld !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL gap%0d: vld=%b busy=%b want 0 1", g, vld, busy);
          end
        end
      end
      drive_bit(1'b1, i == 0, frame_bit(w, i));
    end
    n_vec++;
    if (vld !== 1'b1 || out !== w) begin
      n_err++; $display("FAIL gapped_done: vld=%b out=%b want 1 %b", vld, out, w);
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] w;
    int pulses;
    w = 4'b0010;
    pulses = 0;
    drive_bit(1'b1, 1'b1, 1'b1);
    if (vld === 1'b1) pulses++;
    drive_bit(1'b1, 1'b0, 1'b1);
    if (vld === 1'b1) pulses++;
    for (int i = 0; i < NB; i++) begin
      drive_bit(1'b1, i == 0, frame_bit(w, i));
      if (vld === 1'b1) pulses++;
    end
    n_vec++;
    if (out !== w) begin n_err++; $display("FAIL abort_out: got %b want %b", out, w); end
    drive_bit(1'b0, 1'b0, 1'b0);
    if (vld === 1'b1) pulses++;
    n_vec++;
    if (pulses != 1) begin n_err++; $display("FAIL abort_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w0, w1, w;
    w0 = 4'b1001;
    w1 = 4'b0111;
    for (int c = 0; c < 2 * NB; c++) begin
      w = (c < NB) ? w0 : w1;
      drive_bit(1'b1, (c % NB) == 0, frame_bit(w, c % NB));
      n_vec++;
      if ((c % NB) == NB - 1) begin
        if (vld !== 1'b1 || out !== w) begin
          n_err++; $display("FAIL b2b_done c%0d: vld=%b out=%b want 1 %b", c, vld, out, w);
        end
      end else if (vld !== 1'b0) begin
        n_err++; $display("FAIL b2b_novld c%0d: vld=%b want 0", c, vld);
      end
    end
    drive_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    w = 4'b1100;
    drive_bit(1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    drive_bit(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    n_vec++;
    if (out !== 4'b0000 || busy !== 1'b0 || vld !== 1'b0) begin
      n_err++; $display("FAIL rstmid: out=%b busy=%b vld=%b want 0000 0 0", out, busy, vld);
    end
    for (int i = 0; i < NB; i++) drive_bit(1'b1, i == 0, frame_bit(w, i));
    n_vec++;
    if (vld !== 1'b1 || out !== w) begin
      n_err++; $display("FAIL rstmid_word: vld=%b out=%b want 1 %b", vld, out, w);
    end
    drive_bit(1'b0, 1'b0, 1'b0);
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    logic [DW-1:0] w;
    w = 4'b1011;
    for (int i = 0; i < DW; i++) drive_bit(1'b1, i == 0, w[DW-1-i]);
    drive_bit(1'b1, 1'b0, 1'b1);
    n_vec++;
    if (vld !== 1'b1 || out !== w || err !== 1'b0) begin
      n_err++; $display("FAIL par_good: vld=%b out=%b err=%b want 1 %b 0", vld, out, err, w);
    end
    for (int i = 0; i < DW; i++) drive_bit(1'b1, i == 0, w[DW-1-i]);
    drive_bit(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (vld !== 1'b1 || out !== w || err !== 1'b1) begin
      n_err++; $display("FAIL par_bad: vld=%b out=%b err=%b want 1 %b 1", vld, out, err, w);
    end
    drive_bit(1'b0, 1'b0, 1'b0);
    n_vec++;
    if (vld !== 1'b0 || err !== 1'b1) begin
      n_err++; $display("FAIL par_hold: vld=%b err=%b want 0 1", vld, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word();
    test_gapped();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
